conv_batch_sequencer: RTL and testbench

Batch controller for the fixed(8.8)→float16 converter core. It walks a list of 16-bit operands in shared data memory and, for each one:
- copies the operand into the core's fixed input slots (mem[1:0]);
- resets and starts the core, then waits for its ack;
- copies the result from mem[3:2] to a destination array.

It sits between the host and the core. It owns the data-memory port only while copying; the core owns it at all other times.

---
 rtl/conv_batch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_conv_batch_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_batch_sequencer.sv
// Batch sequencer for the fixed(8.8)->float16 core: copies operands in, runs the core, copies results out.
// Optional ack watchdog: define SEQ_TIMEOUT_EN (uses TIMEOUT_CYCLES and a sticky err flag).
module conv_batch_sequencer #(
  parameter logic [7:0] SRC_BASE = 8'd16,
  parameter logic [7:0] DST_BASE = 8'd64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] job_count,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic [5:0] jobs_done,
  output logic       core_reset,
  output logic       core_start,
  input  logic       core_ack,
  output logic       mem_sel,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, CP_IN, CORE_RST, CORE_GO, CORE_WAIT, CP_OUT, NEXT, DONE
  } state_t;

  state_t     state, state_nx;
  logic [5:0] cnt, idx;
  logic [1:0] step;
  logic [7:0] hold;
  logic [7:0] src_addr, dst_addr;
  logic       wait_expired, force_ff, last_job;

  // step[0] selects the read/write half of a copy pair, step[1] selects the byte
  assign src_addr = SRC_BASE + {1'b0, idx, 1'b0} + {7'd0, step[1]};
  assign dst_addr = DST_BASE + {1'b0, idx, 1'b0} + {7'd0, step[1]};
  assign last_job = ((idx + 6'd1) == cnt);

`ifdef SEQ_TIMEOUT_EN
  logic [12:0] wait_cnt;
  logic        timed_out;

  assign wait_expired = (wait_cnt == 13'(TIMEOUT_CYCLES - 1));
  assign force_ff     = timed_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= 13'd0;
      timed_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      wait_cnt <= (state == CORE_WAIT) ? wait_cnt + 13'd1 : 13'd0;
      if (state == IDLE && start)
        err <= 1'b0;
      if (state == CORE_WAIT && !core_ack && wait_expired) begin
        err       <= 1'b1;
        timed_out <= 1'b1;
      end else if (state == NEXT) begin
        timed_out <= 1'b0;
      end
    end
  end
`else
  assign wait_expired = 1'b0;
  assign force_ff     = 1'b0;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      idx       <= 6'd0;
      step      <= 2'd0;
      hold      <= 8'd0;
      jobs_done <= 6'd0;
    end else begin
      state <= state_nx;
      step  <= (state_nx == state) ? step + 2'd1 : 2'd0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= job_count;
            idx       <= 6'd0;
            jobs_done <= 6'd0;
          end
        end
        CP_IN, CP_OUT: begin
          if (!step[0])
            hold <= mem_rdata;
        end
        NEXT: begin
          idx       <= idx + 6'd1;
          jobs_done <= jobs_done + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so core_ack never reaches an output combinationally
  always_comb begin
    state_nx   = state;
    done       = 1'b0;
    busy       = 1'b1;
    core_reset = 1'b0;
    core_start = 1'b0;
    mem_sel    = 1'b0;
    mem_addr   = 8'd0;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = (job_count == 6'd0) ? DONE : CP_IN;
      end
      CP_IN: begin
        mem_sel = 1'b1;
        if (step[0]) begin
          mem_addr  = {7'd0, step[1]};
          mem_we    = 1'b1;
          mem_wdata = hold;
        end else begin
          mem_addr = src_addr;
        end
        if (step == 2'd3)
          state_nx = CORE_RST;
      end
      CORE_RST: begin
        core_reset = 1'b1;
        state_nx   = CORE_GO;
      end
      CORE_GO: begin
        core_start = 1'b1;
        if (step == 2'd1)
          state_nx = CORE_WAIT;
      end
      CORE_WAIT: begin
        if (core_ack || wait_expired)
          state_nx = CP_OUT;
      end
      CP_OUT: begin
        mem_sel = 1'b1;
        if (step[0]) begin
          mem_addr  = dst_addr;
          mem_we    = 1'b1;
          mem_wdata = force_ff ? 8'hFF : hold;
        end else begin
          mem_addr = {6'd0, 1'b1, step[1]};
        end
        if (step == 2'd3)
          state_nx = NEXT;
      end
      NEXT: begin
        state_nx = last_job ? DONE : CP_IN;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_batch_sequencer.sv
// Directed bench for conv_batch_sequencer: shared memory plus a behavioural converter core.
// Define SEQ_TIMEOUT_EN to also run the ack-watchdog scenario with TIMEOUT_CYCLES=16.
module tb_conv_batch_sequencer;

`ifdef SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 4096;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [5:0] job_count;
  logic       done, busy, err;
  logic [5:0] jobs_done;
  logic       core_reset, core_start;
  bit         core_ack;
  logic       mem_sel, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic       host_we;
  logic [7:0] host_addr, host_wdata;
  bit         preset_ack, never_ack;
  int         ack_delay;
  bit   [1:0] start_seen;
  int         ack_timer;
  logic [15:0] core_result;
  int         n_checks, n_fail;
  int         n_core_reset, n_core_start, n_mem_we;

  always #5 clk = ~clk;

  conv_batch_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .job_count(job_count),
    .done(done), .busy(busy), .err(err), .jobs_done(jobs_done),
    .core_reset(core_reset), .core_start(core_start), .core_ack(core_ack),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  function automatic logic [15:0] q88_to_half(input logic [15:0] q);
    logic [15:0] mag, norm;
    int p;
    mag = q[15] ? (~q + 16'd1) : q;
    if (mag == 16'd0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) p = i;
    norm = mag << (15 - p);
    return {q[15], 5'(p + 7), norm[14:5]};
  endfunction

  // Core acks ack_delay cycles after its second start cycle; only core_reset clears a raised ack
  always @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (mem_sel === 1'b1 && mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    if (core_reset === 1'b1) begin
      core_ack   <= 1'b0;
      start_seen <= 2'd0;
      ack_timer  <= 0;
    end else if (preset_ack) begin
      core_ack <= 1'b1;
    end else if (core_start === 1'b1) begin
      start_seen <= start_seen + 2'd1;
      if (start_seen == 2'd1 && !never_ack) begin
        core_result = q88_to_half({mem[1], mem[0]});
        mem[2] <= core_result[7:0];
        mem[3] <= core_result[15:8];
        if (ack_delay == 0) core_ack <= 1'b1;
        else ack_timer <= ack_delay;
      end
    end else if (ack_timer != 0) begin
      ack_timer <= ack_timer - 1;
      if (ack_timer == 1) core_ack <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (core_reset === 1'b1) n_core_reset <= n_core_reset + 1;
    if (core_start === 1'b1) n_core_start <= n_core_start + 1;
    if (mem_sel === 1'b1 && mem_we === 1'b1) n_mem_we <= n_mem_we + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic fill_dst(input logic [7:0] d);
    for (int i = 0; i < 6; i++) write_mem(8'(64 + i), d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, ".done"}, done, 0);
    check_output({tag, ".busy"}, busy, 0);
    check_output({tag, ".err"}, err, 0);
    check_output({tag, ".jobs_done"}, jobs_done, 0);
    check_output({tag, ".core_reset"}, core_reset, 0);
    check_output({tag, ".core_start"}, core_start, 0);
    check_output({tag, ".mem_sel"}, mem_sel, 0);
    check_output({tag, ".mem_addr"}, mem_addr, 0);
    check_output({tag, ".mem_we"}, mem_we, 0);
    check_output({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  // lat = clock edges from the start cycle to the first done=1 cycle (capped at 400)
  task automatic apply_stimulus(input logic [5:0] count, input bit hold, output int lat);
    job_count = count;
    start     = 1'b1;
    tick();
    lat = 1;
    if (!hold) start = 1'b0;
    while (done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, b_rst, b_go, b_we;
    reset = 1'b1; start = 1'b0; job_count = 6'd0;
    host_we = 1'b0; host_addr = 8'd0; host_wdata = 8'd0;
    preset_ack = 1'b0; never_ack = 1'b0; ack_delay = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    $display("[TB] single job, operand 0x0001");
    write_mem(8'd16, 8'h01); write_mem(8'd17, 8'h00);
    fill_dst(8'hAA);
    b_rst = n_core_reset; b_go = n_core_start;
    apply_stimulus(6'd1, 1'b0, lat);
    check_output("t1.latency", lat, 14);
    check_output("t1.busy", busy, 0);
    check_output("t1.jobs_done", jobs_done, 1);
    check_output("t1.err", err, 0);
    check_output("t1.mem64", mem[64], 8'h00);
    check_output("t1.mem65", mem[65], 8'h1C);
    check_output("t1.mem66_untouched", mem[66], 8'hAA);
    check_output("t1.core_reset_pulses", n_core_reset - b_rst, 1);
    check_output("t1.core_start_cycles", n_core_start - b_go, 2);
    tick();
    check_output("t1.done_dropped", done, 0);

    $display("[TB] three jobs, core waits 3 cycles");
    write_mem(8'd16, 8'h00); write_mem(8'd17, 8'h01);
    write_mem(8'd18, 8'h00); write_mem(8'd19, 8'hFF);
    write_mem(8'd20, 8'h00); write_mem(8'd21, 8'h00);
    fill_dst(8'h55);
    ack_delay = 2;
    b_rst = n_core_reset; b_go = n_core_start; b_we = n_mem_we;
    apply_stimulus(6'd3, 1'b0, lat);
    check_output("t2.latency", lat, 46);
    check_output("t2.jobs_done", jobs_done, 3);
    check_output("t2.mem64", mem[64], 8'h00);
    check_output("t2.mem65", mem[65], 8'h3C);
    check_output("t2.mem66", mem[66], 8'h00);
    check_output("t2.mem67", mem[67], 8'hBC);
    check_output("t2.mem68", mem[68], 8'h00);
    check_output("t2.mem69", mem[69], 8'h00);
    check_output("t2.core_reset_pulses", n_core_reset - b_rst, 3);
    check_output("t2.core_start_cycles", n_core_start - b_go, 6);
    check_output("t2.mem_writes", n_mem_we - b_we, 12);
    tick();

    $display("[TB] empty batch");
    b_rst = n_core_reset; b_go = n_core_start; b_we = n_mem_we;
    apply_stimulus(6'd0, 1'b0, lat);
    check_output("t3.latency", lat, 1);
    check_output("t3.jobs_done", jobs_done, 0);
    check_output("t3.core_reset_pulses", n_core_reset - b_rst, 0);
    check_output("t3.core_start_cycles", n_core_start - b_go, 0);
    check_output("t3.mem_writes", n_mem_we - b_we, 0);
    tick();

    $display("[TB] start held high through DONE");
    ack_delay = 0;
    fill_dst(8'hAA);
    b_go = n_core_start;
    apply_stimulus(6'd1, 1'b1, lat);
    check_output("t4.latency", lat, 14);
    check_output("t4.mem65", mem[65], 8'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("t4.done_held", done, 1);
      check_output("t4.busy_held", busy, 0);
    end
    check_output("t4.no_restart", n_core_start - b_go, 2);
    check_output("t4.jobs_done", jobs_done, 1);
    start = 1'b0;
    tick();
    check_output("t4.done_after_drop", done, 0);
    check_output("t4.busy_after_drop", busy, 0);

    $display("[TB] stale ack, reset mid-batch, fresh batch");
    write_mem(8'd16, 8'h00); write_mem(8'd17, 8'h02);
    write_mem(8'd18, 8'h80); write_mem(8'd19, 8'h00);
    write_mem(8'd20, 8'h00); write_mem(8'd21, 8'h80);
    fill_dst(8'h55);
    ack_delay = 3;
    preset_ack = 1'b1;
    tick();
    preset_ack = 1'b0;
    job_count = 6'd3;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if (c == 5) check_output("t5.core_reset_c5", core_reset, 1);
      if (c == 8) begin
        check_output("t5.wait_core_start_c8", core_start, 0);
        check_output("t5.wait_mem_sel_c8", mem_sel, 0);
      end
      if (c == 11) check_output("t5.wait_mem_sel_c11", mem_sel, 0);
      if (c == 12) begin
        check_output("t5.cpout_mem_sel_c12", mem_sel, 1);
        check_output("t5.cpout_addr_c12", mem_addr, 8'h02);
      end
      if (c == 40) begin
        check_output("t5.jobs_done_c40", jobs_done, 2);
        check_output("t5.busy_c40", busy, 1);
        check_output("t5.mem_sel_c40", mem_sel, 0);
      end
    end
    reset = 1'b1;
    b_we = n_mem_we;
    tick();
    check_reset_outputs("t5.reset");
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_output("t5.no_writes_after_reset", n_mem_we - b_we, 0);
    check_output("t5.mem64", mem[64], 8'h00);
    check_output("t5.mem65", mem[65], 8'h40);
    check_output("t5.mem66", mem[66], 8'h00);
    check_output("t5.mem67", mem[67], 8'h38);
    check_output("t5.mem68_abandoned", mem[68], 8'h55);
    check_output("t5.mem69_abandoned", mem[69], 8'h55);
    fill_dst(8'h55);
    ack_delay = 0;
    apply_stimulus(6'd3, 1'b0, lat);
    check_output("t5.fresh_latency", lat, 40);
    check_output("t5.fresh_jobs_done", jobs_done, 3);
    check_output("t5.fresh_mem64", mem[64], 8'h00);
    check_output("t5.fresh_mem65", mem[65], 8'h40);
    check_output("t5.fresh_mem66", mem[66], 8'h00);
    check_output("t5.fresh_mem67", mem[67], 8'h38);
    check_output("t5.fresh_mem68", mem[68], 8'h00);
    check_output("t5.fresh_mem69", mem[69], 8'hD8);
    check_output("t5.fresh_err", err, 0);
    tick();

`ifdef SEQ_TIMEOUT_EN
    $display("[TB] core never acks, watchdog fires");
    never_ack = 1'b1;
    fill_dst(8'h55);
    apply_stimulus(6'd2, 1'b0, lat);
    check_output("t6.latency", lat, 57);
    check_output("t6.err", err, 1);
    check_output("t6.jobs_done", jobs_done, 2);
    check_output("t6.mem64", mem[64], 8'hFF);
    check_output("t6.mem65", mem[65], 8'hFF);
    check_output("t6.mem66", mem[66], 8'hFF);
    check_output("t6.mem67", mem[67], 8'hFF);
    tick();
    never_ack = 1'b0;
    apply_stimulus(6'd0, 1'b0, lat);
    check_output("t6.err_cleared", err, 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
